ram_cmd_ctrl: RTL and testbench

Command front-end for the 8-bit x 16-entry RAM. Accepts read/write commands through a valid/ready port into a small command FIFO and sequences them onto the RAM's `valid`/`wr_rd`/`add`/`writedata` inputs. Returns read data on a one-cycle response strobe once the RAM's registered `readdata` has settled. Sits directly upstream of the RAM; the RAM's `readdata` feeds back into this block.

---
 rtl/ram_ctrl_pkg.sv | 27 ++
 rtl/ram_cmd_fifo.sv | 51 +++++
 rtl/ram_cmd_ctrl.sv | 136 +++++++++++++
 tb/tb_ram_cmd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared widths, FSM state and FIFO entry layout for ram_cmd_ctrl.
// Defining RAM_FILL_EN adds the FILL state and the per-entry fill bit.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned RAM_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2
`ifdef RAM_FILL_EN
    , ST_FILL   = 2'd3
`endif
  } state_t;

  typedef struct packed {
`ifdef RAM_FILL_EN
    logic              fill;
`endif
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_entry_t;

endpackage

// File: rtl/ram_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through head, push/pop,
// full/empty flags and occupancy count.
module ram_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ram_cmd_ctrl.sv
// Command front-end for the 8x16 RAM: queues read/write commands and sequences
// them onto the RAM port. Defining RAM_FILL_EN enables whole-RAM fill commands.
module ram_cmd_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_fill,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_valid,
  output logic              ram_wr_rd,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam int unsigned ENTRY_W = $bits(cmd_entry_t);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  state_t             state;
  cmd_entry_t         push_entry;
  cmd_entry_t         head;
  logic [ENTRY_W-1:0] head_bits;
  logic [CNT_W-1:0]   count_unused;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

`ifdef RAM_FILL_EN
  assign push_entry = '{fill: cmd_fill, wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
`else
  logic fill_unused;
  assign fill_unused = cmd_fill;
  assign push_entry  = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
`endif

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == ST_IDLE) && !empty;
  assign head      = cmd_entry_t'(head_bits);

  ram_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (ENTRY_W'(push_entry)),
    .pop   (pop),
    .dout  (head_bits),
    .full  (full),
    .empty (empty),
    .count (count_unused)
  );

  // Sequencer; ram_wr_rd is only ever high in a cycle that is an issued write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      ram_valid     <= 1'b0;
      ram_wr_rd     <= 1'b0;
      ram_add       <= '0;
      ram_writedata <= '0;
      rsp_valid     <= 1'b0;
      rsp_addr      <= '0;
      rsp_rdata     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            ram_valid <= 1'b1;
`ifdef RAM_FILL_EN
            if (head.fill) begin
              ram_wr_rd     <= 1'b1;
              ram_add       <= '0;
              ram_writedata <= head.wdata;
              state         <= ST_FILL;
            end else
`endif
            if (head.wr) begin
              ram_wr_rd     <= 1'b1;
              ram_add       <= head.addr;
              ram_writedata <= head.wdata;
            end else begin
              ram_wr_rd <= 1'b0;
              ram_add   <= head.addr;
              state     <= ST_RD_ISSUE;
            end
          end else begin
            ram_valid <= 1'b0;
            ram_wr_rd <= 1'b0;
          end
        end
        ST_RD_ISSUE: begin
          ram_valid <= 1'b0;
          state     <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_addr  <= ram_add;
          rsp_rdata <= ram_readdata;
          state     <= ST_IDLE;
        end
`ifdef RAM_FILL_EN
        // Walk every address; completion reports the last address and fill value.
        ST_FILL: begin
          if (ram_add == ADDR_W'(RAM_WORDS - 1)) begin
            ram_valid <= 1'b0;
            ram_wr_rd <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_addr  <= ram_add;
            rsp_rdata <= ram_writedata;
            state     <= ST_IDLE;
          end else begin
            ram_add <= ram_add + ADDR_W'(1);
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Bench for ram_cmd_ctrl: behavioural RAM, in-order transaction model and
// directed scenarios. Honours RAM_FILL_EN the same way as the design.
module tb_ram_cmd_ctrl;
  import ram_ctrl_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_wr, cmd_fill;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [3:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       ram_valid, ram_wr_rd;
  logic [3:0] ram_add;
  logic [7:0] ram_writedata, ram_readdata;

  always #5 clk = ~clk;

  ram_cmd_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_fill(cmd_fill),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .ram_valid(ram_valid), .ram_wr_rd(ram_wr_rd), .ram_add(ram_add),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  typedef struct {bit wr; bit first; logic [3:0] addr; logic [7:0] data;} iss_t;
  typedef struct {logic [3:0] addr; logic [7:0] data;} rsp_t;

  iss_t       iss_q[$];
  rsp_t       rsp_q[$];
  rsp_t       rsp_log[$];
  int         rsp_edge[$];
  int         wr_edge[$];
  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  int total = 0, bad = 0, cyc = 0, pushed = 0, popped = 0, max_occ = 0, last_acc = 0;
  bit saw_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // In-order model: each accepted command becomes its RAM issue cycles and response.
  task automatic model_push(input bit f, input bit w, input logic [3:0] a, input logic [7:0] d);
    if (f) begin
      for (int i = 0; i < 16; i++) begin
        iss_q.push_back('{wr: 1'b1, first: (i == 0), addr: 4'(i), data: d});
        ref_mem[i] = d;
      end
      rsp_q.push_back('{addr: 4'd15, data: d});
    end else if (w) begin
      iss_q.push_back('{wr: 1'b1, first: 1'b1, addr: a, data: d});
      ref_mem[a] = d;
    end else begin
      iss_q.push_back('{wr: 1'b0, first: 1'b1, addr: a, data: 8'h00});
      rsp_q.push_back('{addr: a, data: ref_mem[a]});
    end
  endtask

  // Behavioural RAM: writes whenever wr_rd is high, registered read on valid.
  initial begin
    ram_readdata = 8'h00;
    forever begin
      @(posedge clk);
      if (ram_wr_rd) mem[ram_add] <= ram_writedata;
      else if (ram_valid) ram_readdata <= mem[ram_add];
    end
  end

  // Accept monitor and edge counter.
  initial forever begin
    @(posedge clk);
    if (rst && cmd_valid && cmd_ready) begin
`ifdef RAM_FILL_EN
      model_push(cmd_fill, cmd_wr, cmd_addr, cmd_wdata);
`else
      model_push(1'b0, cmd_wr, cmd_addr, cmd_wdata);
`endif
      pushed++;
      last_acc = cyc;
    end
    cyc++;
  end

  // Per-cycle compare against the model.
  initial begin
    iss_t e;
    rsp_t r;
    int   occ;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("wr_guard", ram_wr_rd & ~ram_valid, 0);
        if (ram_wr_rd) wr_edge.push_back(cyc - 1);
        if (ram_valid) begin
          if (iss_q.size() == 0) chk("unexpected_issue", ram_valid, 0);
          else begin
            e = iss_q.pop_front();
            chk("issue_wr", ram_wr_rd, e.wr);
            chk("issue_addr", ram_add, e.addr);
            if (e.wr) chk("issue_data", ram_writedata, e.data);
            if (e.first) popped++;
          end
        end
        if (rsp_valid) begin
          rsp_log.push_back('{addr: rsp_addr, data: rsp_rdata});
          rsp_edge.push_back(cyc - 1);
          if (rsp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
          else begin
            r = rsp_q.pop_front();
            chk("rsp_addr", rsp_addr, r.addr);
            chk("rsp_data", rsp_rdata, r.data);
          end
        end
        occ = pushed - popped;
        if (occ > max_occ) max_occ = occ;
        if (!cmd_ready) saw_full = 1'b1;
        chk("cmd_ready", cmd_ready, occ < int'(DEPTH));
      end
    end
  end

  task automatic send(input bit f, input bit w, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_fill = f; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
    forever begin
      @(posedge clk);
      n++;
      if (cmd_ready) break;
      if (n >= 100) begin chk("send_timeout", n, 0); break; end
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", iss_q.size() + rsp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rsp_log.delete(); rsp_edge.delete(); wr_edge.delete();
    max_occ = 0; saw_full = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    cmd_valid = 1'b0;
    iss_q.delete(); rsp_q.delete();
    pushed = 0; popped = 0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a_w, a_r;
    for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_fill = 1'b0; cmd_addr = 4'h0; cmd_wdata = 8'h00;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_valid", ram_valid, 0);
    chk("rst_ram_wr_rd", ram_wr_rd, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ram_add", ram_add, 0);
    chk("rst_ram_wdata", ram_writedata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Write 0x02 to address 1, read it back.
    clear_logs();
    send(0, 1, 4'd1, 8'h02); a_w = last_acc;
    send(0, 0, 4'd1, 8'h00); a_r = last_acc;
    drain();
    chk("t1_wr_cycles", wr_edge.size(), 1);
    chk("t1_wr_latency", wr_edge[0] - a_w, 1);
    chk("t1_rsp_count", rsp_log.size(), 1);
    chk("t1_rsp_addr", rsp_log[0].addr, 4'd1);
    chk("t1_rsp_data", rsp_log[0].data, 8'h02);
    chk("t1_rd_latency", rsp_edge[0] - a_r, 3);

    // Back-to-back writes then reads.
    clear_logs();
    for (int i = 0; i < 4; i++) send(0, 1, 4'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) send(0, 0, 4'(i), 8'h00);
    drain();
    chk("t2_wr_cycles", wr_edge.size(), 4);
    chk("t2_wr_span", wr_edge[3] - wr_edge[0], 3);
    chk("t2_rsp_count", rsp_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_rsp_data", rsp_log[i].data, 8'h10 + 8'(i));
    for (int i = 1; i < 4; i++) chk("t2_rsp_gap", rsp_edge[i] - rsp_edge[i-1], 3);

    // Stream reads to fill the FIFO.
    clear_logs();
    for (int i = 0; i < 8; i++) send(0, 0, 4'(i % 4), 8'hEE);
    drain();
    chk("t3_saw_full", saw_full, 1);
    chk("t3_max_occ", max_occ, DEPTH);
    chk("t3_rsp_count", rsp_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("t3_rsp_data", rsp_log[i].data, 8'h10 + 8'(i % 4));

    // Reset while a read sits in RD_ISSUE.
    clear_logs();
    send(0, 0, 4'd2, 8'h00);
    @(posedge clk); #1;
    chk("t4_in_issue", ram_valid, 1);
    do_reset(2);
    chk("t4_ready_after", cmd_ready, 1);
    chk("t4_valid_after", ram_valid, 0);
    repeat (6) @(posedge clk); #1;
    chk("t4_no_rsp", rsp_log.size(), 0);
    send(0, 0, 4'd2, 8'h00);
    drain();
    chk("t4_rsp_count", rsp_log.size(), 1);
    chk("t4_rsp_data", rsp_log[0].data, 8'h12);

    // Read with 0xFF on wdata must not write.
    clear_logs();
    send(0, 0, 4'd3, 8'hFF);
    send(0, 0, 4'd3, 8'h00);
    drain();
    chk("t5_wr_cycles", wr_edge.size(), 0);
    chk("t5_rsp_count", rsp_log.size(), 2);
    chk("t5_rsp_data", rsp_log[1].data, 8'h13);

`ifdef RAM_FILL_EN
    clear_logs();
    send(1, 1, 4'd0, 8'hA5); a_w = last_acc;
    drain();
    chk("t6_wr_cycles", wr_edge.size(), 16);
    chk("t6_wr_start", wr_edge[0] - a_w, 1);
    chk("t6_wr_span", wr_edge[15] - wr_edge[0], 15);
    chk("t6_rsp_count", rsp_log.size(), 1);
    chk("t6_rsp_addr", rsp_log[0].addr, 4'd15);
    chk("t6_rsp_data", rsp_log[0].data, 8'hA5);
    chk("t6_done_latency", rsp_edge[0] - a_w, 17);
    clear_logs();
    send(0, 0, 4'd0, 8'h00);
    send(0, 0, 4'd7, 8'h00);
    send(0, 0, 4'd15, 8'h00);
    drain();
    chk("t6_rd_count", rsp_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("t6_rd_data", rsp_log[i].data, 8'hA5);
`else
    // Fill bit is ignored: executes as a plain write.
    clear_logs();
    send(1, 1, 4'd9, 8'h3C);
    send(0, 0, 4'd9, 8'h00);
    drain();
    chk("t6_wr_cycles", wr_edge.size(), 1);
    chk("t6_rsp_count", rsp_log.size(), 1);
    chk("t6_rsp_data", rsp_log[0].data, 8'h3C);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
